// File: rtl/mem_pkg.sv
// Shared constants and types for the main-memory arbiter slice.
// Block geometry, FSM state encoding and requester (owner) encoding.
// Imported by mem_arbiter and rr_arb2.
package mem_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int BEAT_W      = $clog2(BLOCK_WORDS);

  // Clears the word-in-block and byte-in-word bits of a block address.
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLOCK_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: 2-way round-robin picker between I-cache (bit 0) and D-cache (bit 1).
// Latency: purely combinational, no state of its own.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req_i = {dc,ic} requests, last_owner_i = previous burst owner,
//        grant_o = {dc,ic} one-hot pick, 00 when nobody requests.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_owner_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Tie: whoever did not own the last burst wins.
      2'b11:   grant_o = (last_owner_i == OWN_DC) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares the single main-memory port between I-cache refills and D-cache refill/writeback.
// Latency: 1 cycle grant, BLOCK_WORDS memory handshakes, 1 cycle done pulse.
// Backpressure: each beat waits on mem_ready; requesters hold req until their done pulse.
// Ports: clk/reset (async active-low); ic_* and dc_* cache-side request/response;
//        rdata/beat/grant shared status; mem_* word-wide memory handshake.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic [DATA_W-1:0] rdata,
  output logic [BEAT_W-1:0] beat,
  output logic [1:0]        grant,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  state_e            state_q;
  logic [1:0]        grant_q;
  logic [BEAT_W-1:0] beat_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  owner_e            last_owner_q;

  logic [1:0]        pick;
  logic [ADDR_W-1:0] base_d;
  logic              we_d;

  rr_arb2 u_rr (
    .req_i        ({dc_req, ic_req}),
    .last_owner_i (last_owner_q),
    .grant_o      (pick)
  );

  // Values latched at grant; later changes on addr/we are ignored.
  always_comb begin
    base_d = (pick[1] ? dc_addr : ic_addr) & BASE_MASK;
    we_d   = pick[1] & dc_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      beat_q       <= '0;
      base_q       <= '0;
      we_q         <= 1'b0;
      last_owner_q <= OWN_DC;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pick) begin
            grant_q <= pick;
            base_q  <= base_d;
            we_q    <= we_d;
            beat_q  <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (mem_ready) begin
            // Beat stays at the last index through DONE; it is only cleared on the way to IDLE.
            if (beat_q == LAST_BEAT) begin
              state_q <= DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        DONE: begin
          last_owner_q <= owner_e'(grant_q[1]);
          grant_q      <= 2'b00;
          beat_q       <= '0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic in_xfer;
  logic in_done;
  logic rd_hit;

  assign in_xfer = (state_q == XFER);
  assign in_done = (state_q == DONE);
  // mem_ready outside XFER never reaches a requester.
  assign rd_hit  = in_xfer & mem_ready & ~we_q;

  assign ic_rvalid = rd_hit & grant_q[0];
  assign dc_rvalid = rd_hit & grant_q[1];
  assign ic_done   = in_done & grant_q[0];
  assign dc_done   = in_done & grant_q[1];

  assign rdata     = mem_rdata;
  assign beat      = beat_q;
  assign grant     = grant_q;

  assign mem_req   = in_xfer;
  assign mem_we    = in_xfer & we_q;
  assign mem_addr  = in_xfer ? (base_q + ADDR_W'({beat_q, 2'b00})) : '0;
  assign mem_wdata = (in_xfer & we_q) ? dc_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a LAT-cycle word memory model.
// Latency: memory returns mem_ready on the LAT-th cycle of each held request.
// Backpressure: modelled by LAT; requesters drop req when they see their done pulse.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_rvalid, ic_done;
  logic              dc_req, dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_rvalid, dc_done;
  logic [DATA_W-1:0] rdata;
  logic [BEAT_W-1:0] beat;
  logic [1:0]        grant;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .rdata(rdata), .beat(beat), .grant(grant),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // D-cache supplies the word for the current beat.
  logic [DATA_W-1:0] wbase = '0;
  assign dc_wdata = wbase + DATA_W'(beat);

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem     [0:1023];
  logic [DATA_W-1:0] ref_mem [0:1023];
  bit preload = 1'b0;
  int lat = 1;
  int wait_cnt;

  assign mem_ready = mem_req && (wait_cnt == lat - 1);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= DATA_W'(i * 4);
    end else if (reset && mem_req && mem_ready && mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // ---------------- monitor ----------------
  logic [ADDR_W-1:0] xa_q [$];
  logic              xw_q [$];
  logic [DATA_W-1:0] rd_q [$];
  int ic_done_n, dc_done_n, side_err;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_req && mem_ready) begin
        xa_q.push_back(mem_addr);
        xw_q.push_back(mem_we);
      end
      if (ic_rvalid || dc_rvalid) rd_q.push_back(rdata);
      if (ic_done) ic_done_n++;
      if (dc_done) dc_done_n++;
      if ((ic_rvalid || ic_done) && !grant[0]) side_err++;
      if ((dc_rvalid || dc_done) && !grant[1]) side_err++;
      if (ic_rvalid && dc_rvalid) side_err++;
    end
  end

  // Reference arbitration state: 1 = D-cache owned the last completed burst.
  bit model_last = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    xa_q.delete(); xw_q.delete(); rd_q.delete();
    ic_done_n = 0; dc_done_n = 0; side_err = 0;
  endtask

  task automatic wait_grant(input int budget, output logic [1:0] g);
    int cnt = 0;
    while (grant == 2'b00 && cnt < budget) begin
      tick();
      cnt++;
    end
    g = grant;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ic_done || dc_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    reset = 1'b0; ic_req = 1'b1; dc_req = 1'b0; ic_addr = 32'h0; dc_addr = 32'h0; dc_we = 1'b0;
    repeat (3) tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if (beat !== '0) begin n_fail++; $display("FAIL reset_beat: got %0d want 0", beat); end
    reset = 1'b1;
    tick();
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL reset_release_grant: got %b want 01", grant); end
    wait_done(50, cyc);
    ic_req = 1'b0;
    model_last = 1'b0;
    tick();
    n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL reset_burst_done: got timeout want done"); end
  endtask

  task automatic test_ic_refill();
    int cyc;
    lat = 1;
    clear_mon();
    ic_addr = 32'h104; ic_req = 1'b1;
    wait_done(50, cyc);
    n_tests++; if (cyc !== 1 + BLOCK_WORDS * lat) begin n_fail++; $display("FAIL ic_done_cycle: got %0d want %0d", cyc, 1 + BLOCK_WORDS * lat); end
    n_tests++; if (ic_done !== 1'b1 || dc_done !== 1'b0) begin n_fail++; $display("FAIL ic_done_side: got ic=%b dc=%b want ic=1 dc=0", ic_done, dc_done); end
    ic_req = 1'b0;
    model_last = 1'b0;
    tick();
    n_tests++; if (grant !== 2'b00 || beat !== '0) begin n_fail++; $display("FAIL ic_post_idle: got grant=%b beat=%0d want 00/0", grant, beat); end
    tick();
    n_tests++; if (xa_q.size() !== BLOCK_WORDS) begin n_fail++; $display("FAIL ic_beats: got %0d want %0d", xa_q.size(), BLOCK_WORDS); end
    n_tests++; if (rd_q.size() !== BLOCK_WORDS) begin n_fail++; $display("FAIL ic_rvalids: got %0d want %0d", rd_q.size(), BLOCK_WORDS); end
    for (int i = 0; i < BLOCK_WORDS && i < xa_q.size() && i < rd_q.size(); i++) begin
      n_tests++; if (xa_q[i] !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL ic_addr[%0d]: got %h want %h", i, xa_q[i], 32'h100 + 32'(4 * i)); end
      n_tests++; if (rd_q[i] !== ref_mem[64 + i]) begin n_fail++; $display("FAIL ic_rdata[%0d]: got %h want %h", i, rd_q[i], ref_mem[64 + i]); end
    end
    n_tests++; if (ic_done_n !== 1 || dc_done_n !== 0 || side_err !== 0) begin n_fail++; $display("FAIL ic_done_count: got ic=%0d dc=%0d side=%0d want 1/0/0", ic_done_n, dc_done_n, side_err); end
  endtask

  task automatic test_dc_writeback();
    int cyc;
    lat = 3;
    clear_mon();
    wbase = 32'hA0; dc_we = 1'b1; dc_addr = 32'h200; dc_req = 1'b1;
    wait_done(100, cyc);
    n_tests++; if (cyc !== 1 + BLOCK_WORDS * lat) begin n_fail++; $display("FAIL dc_done_cycle: got %0d want %0d", cyc, 1 + BLOCK_WORDS * lat); end
    dc_req = 1'b0; dc_we = 1'b0;
    model_last = 1'b1;
    tick();
    for (int i = 0; i < BLOCK_WORDS; i++) ref_mem[128 + i] = 32'hA0 + 32'(i);
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      n_tests++; if (mem[128 + i] !== ref_mem[128 + i]) begin n_fail++; $display("FAIL dc_wb_mem[%0d]: got %h want %h", i, mem[128 + i], ref_mem[128 + i]); end
    end
    n_tests++; if (xw_q.size() !== BLOCK_WORDS || xw_q.sum() with (int'(item)) !== BLOCK_WORDS) begin n_fail++; $display("FAIL dc_wb_we: got %0d writes want %0d", xw_q.sum() with (int'(item)), BLOCK_WORDS); end
    n_tests++; if (rd_q.size() !== 0) begin n_fail++; $display("FAIL dc_wb_rvalid: got %0d want 0", rd_q.size()); end
    n_tests++; if (dc_done_n !== 1 || ic_done_n !== 0 || side_err !== 0) begin n_fail++; $display("FAIL dc_wb_done: got dc=%0d ic=%0d side=%0d want 1/0/0", dc_done_n, ic_done_n, side_err); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g, exp_g;
    logic [1:0] order [4];
    int cyc;
    lat = 1;
    dc_we = 1'b0; ic_addr = 32'h300; dc_addr = 32'h340;
    ic_req = 1'b1; dc_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = model_last ? 2'b01 : 2'b10;
      wait_grant(10, g);
      order[k] = g;
      n_tests++; if (g !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, g, exp_g); end
      wait_done(30, cyc);
      n_tests++; if ({dc_done, ic_done} !== exp_g) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", k, {dc_done, ic_done}, exp_g); end
      if (k == 3) begin ic_req = 1'b0; dc_req = 1'b0; end
      else if (g[0]) ic_req = 1'b0;
      else dc_req = 1'b0;
      model_last = exp_g[1];
      tick();
      if (k < 3) begin
        if (g[0]) ic_req = 1'b1;
        else dc_req = 1'b1;
      end
    end
    n_tests++; if ({order[0], order[1], order[2], order[3]} !== 8'b01_10_01_10) begin n_fail++; $display("FAIL rr_order: got %b want 01100110", {order[0], order[1], order[2], order[3]}); end
  endtask

  task automatic test_req_drop();
    int cyc, cnt;
    lat = 3;
    clear_mon();
    dc_we = 1'b0; dc_addr = 32'h3C0; dc_req = 1'b1;
    cnt = 0;
    while (!(grant == 2'b10 && beat == 1) && cnt < 40) begin tick(); cnt++; end
    // Withdraw the request and scramble the latched-at-grant inputs.
    dc_req = 1'b0; dc_addr = 32'hFF0; dc_we = 1'b1;
    wait_done(60, cyc);
    n_tests++; if (dc_done !== 1'b1) begin n_fail++; $display("FAIL drop_done: got %b want 1", dc_done); end
    model_last = 1'b1;
    tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL drop_idle_grant: got %b want 00", grant); end
    repeat (3) tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL drop_stay_idle: got %b want 00", grant); end
    n_tests++; if (xa_q.size() !== BLOCK_WORDS || rd_q.size() !== BLOCK_WORDS) begin n_fail++; $display("FAIL drop_beats: got %0d/%0d want %0d", xa_q.size(), rd_q.size(), BLOCK_WORDS); end
    for (int i = 0; i < BLOCK_WORDS && i < xa_q.size() && i < rd_q.size(); i++) begin
      n_tests++; if (xa_q[i] !== 32'h3C0 + 32'(4 * i) || xw_q[i] !== 1'b0) begin n_fail++; $display("FAIL drop_addr[%0d]: got %h we=%b want %h we=0", i, xa_q[i], xw_q[i], 32'h3C0 + 32'(4 * i)); end
      n_tests++; if (rd_q[i] !== ref_mem[240 + i]) begin n_fail++; $display("FAIL drop_rdata[%0d]: got %h want %h", i, rd_q[i], ref_mem[240 + i]); end
    end
    n_tests++; if (mem[1020] !== ref_mem[1020]) begin n_fail++; $display("FAIL drop_no_write: got %h want %h", mem[1020], ref_mem[1020]); end
    n_tests++; if (dc_done_n !== 1 || side_err !== 0) begin n_fail++; $display("FAIL drop_done_count: got %0d side=%0d want 1/0", dc_done_n, side_err); end
    dc_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc, cnt;
    lat = 1;
    ic_addr = 32'h040; ic_req = 1'b1;
    cnt = 0;
    while (!(grant == 2'b01 && beat == 2) && cnt < 20) begin tick(); cnt++; end
    n_tests++; if (cnt >= 20) begin n_fail++; $display("FAIL rst_mid_reach: got timeout want beat 2"); end
    dc_we = 1'b0; dc_addr = 32'h080; dc_req = 1'b1;
    reset = 1'b0;
    #1;
    n_tests++; if (grant !== 2'b00 || mem_req !== 1'b0 || beat !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got grant=%b req=%b beat=%0d want 00/0/0", grant, mem_req, beat); end
    n_tests++; if (ic_rvalid !== 1'b0 || mem_addr !== '0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem: got rv=%b addr=%h we=%b want 0/0/0", ic_rvalid, mem_addr, mem_we); end
    ic_req = 1'b0;
    model_last = 1'b1;
    tick();
    reset = 1'b1;
    clear_mon();
    tick();
    n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rst_mid_regrant: got %b want 10", grant); end
    wait_done(40, cyc);
    dc_req = 1'b0;
    tick();
    n_tests++; if (rd_q.size() !== BLOCK_WORDS || rd_q[0] !== ref_mem[32]) begin n_fail++; $display("FAIL rst_mid_dc_read: got n=%0d first=%h want %0d/%h", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hx, BLOCK_WORDS, ref_mem[32]); end
  endtask

  task automatic test_random();
    logic [1:0] g, exp_g;
    logic [1:0] seq [2];
    int pattern, n, cyc, idx;
    logic [ADDR_W-1:0] a_ic, a_dc, base;
    logic we;
    for (int it = 0; it < 16; it++) begin
      pattern = $urandom_range(1, 3);
      lat = ($urandom_range(0, 1) == 1) ? 3 : 1;
      a_ic = ADDR_W'($urandom_range(0, 4095));
      a_dc = ADDR_W'($urandom_range(0, 4095));
      we = 1'($urandom_range(0, 1));
      wbase = $urandom;
      ic_addr = a_ic; dc_addr = a_dc; dc_we = we;
      if (pattern == 3) begin
        seq[0] = model_last ? 2'b01 : 2'b10;
        seq[1] = ~seq[0];
        n = 2;
      end else begin
        seq[0] = 2'(pattern);
        n = 1;
      end
      ic_req = pattern[0]; dc_req = pattern[1];
      for (int b = 0; b < n; b++) begin
        exp_g = seq[b];
        clear_mon();
        wait_grant(10, g);
        n_tests++; if (g !== exp_g) begin n_fail++; $display("FAIL rand_grant[%0d.%0d]: got %b want %b", it, b, g, exp_g); end
        wait_done(40, cyc);
        n_tests++; if ({dc_done, ic_done} !== exp_g) begin n_fail++; $display("FAIL rand_done[%0d.%0d]: got %b want %b", it, b, {dc_done, ic_done}, exp_g); end
        if (exp_g[0]) ic_req = 1'b0; else dc_req = 1'b0;
        model_last = exp_g[1];
        tick();
        base = (exp_g[1] ? a_dc : a_ic) & ~ADDR_W'(BLOCK_WORDS * 4 - 1);
        n_tests++; if (xa_q.size() !== BLOCK_WORDS || side_err !== 0) begin n_fail++; $display("FAIL rand_beats[%0d.%0d]: got %0d side=%0d want %0d/0", it, b, xa_q.size(), side_err, BLOCK_WORDS); end
        for (int i = 0; i < BLOCK_WORDS && i < xa_q.size(); i++) begin
          idx = int'(base >> 2) + i;
          n_tests++; if (xa_q[i] !== base + ADDR_W'(4 * i)) begin n_fail++; $display("FAIL rand_addr[%0d.%0d.%0d]: got %h want %h", it, b, i, xa_q[i], base + ADDR_W'(4 * i)); end
          if (exp_g[1] && we) begin
            ref_mem[idx] = wbase + DATA_W'(i);
            n_tests++; if (mem[idx] !== ref_mem[idx]) begin n_fail++; $display("FAIL rand_wr[%0d.%0d.%0d]: got %h want %h", it, b, i, mem[idx], ref_mem[idx]); end
          end else if (i < rd_q.size()) begin
            n_tests++; if (rd_q[i] !== ref_mem[idx]) begin n_fail++; $display("FAIL rand_rd[%0d.%0d.%0d]: got %h want %h", it, b, i, rd_q[i], ref_mem[idx]); end
          end else begin
            n_tests++; n_fail++; $display("FAIL rand_rd_missing[%0d.%0d.%0d]: got none want %h", it, b, i, ref_mem[idx]);
          end
        end
      end
      ic_req = 1'b0; dc_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = DATA_W'(i * 4);
    preload = 1'b1;
    tick();
    preload = 1'b0;
    clear_mon();
    test_reset();
    test_ic_refill();
    test_dc_writeback();
    test_round_robin();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
